// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
// Holds the sequencer state encoding, requester index constants and the
// default address/data widths used by dmem_arbiter and its picker.
package dmem_arbiter_pkg;

    localparam int AW_DEFAULT = 32;
    localparam int DW_DEFAULT = 32;

    // Requester indices; also the value stored in the winner/last registers.
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    // Sequencer states.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCESS = 2'd1;
    localparam state_t ST_RESP   = 2'd2;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin picker (combinational).
// Ports:
//   req    in  2  request vector, bit i = requester i
//   last   in  1  index of the requester served most recently
//   winner out 1  index of the requester to serve next
//   any    out 1  at least one request is pending
module rr_pick2
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner,
    output logic       any
);

    // Single requester wins outright; on contention the one not served last wins.
    always_comb begin
        winner = REQ_CPU;
        any    = 1'b0;
        if (req == 2'b11) begin
            winner = ~last;
            any    = 1'b1;
        end else if (req == 2'b10) begin
            winner = REQ_DMA;
            any    = 1'b1;
        end else if (req == 2'b01) begin
            winner = REQ_CPU;
            any    = 1'b1;
        end else begin
            winner = REQ_CPU;
            any    = 1'b0;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one DataMemory between the CPU datapath (requester 0) and a
// DMA/debug loader (requester 1) with an IDLE -> ACCESS -> RESP sequencer.
// Ports:
//   CLK, Reset                    clock, synchronous active-high reset
//   req0/we0/addr0/wdata0, ack0   CPU request and one-cycle completion pulse
//   req1/we1/addr1/wdata1, ack1   DMA/debug request and completion pulse
//   rdata                         read data, valid while ack0 or ack1 is high
//   grant                         one-hot owner during ACCESS and RESP
//   cpu_stall                     CPU access pending (req0 & ~ack0)
//   mem_rd/mem_wr/mem_addr/mem_wdata/mem_rdata  DataMemory interface
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic [1:0]    grant,
    output logic          cpu_stall,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    state_t        state_r;
    logic          last_r;
    logic          win_r;
    logic          we_r;
    logic [AW-1:0] addr_r;
    logic [DW-1:0] wdata_r;
    logic [DW-1:0] rdata_r;
    logic [1:0]    grant_r;
    logic          ack0_r;
    logic          ack1_r;
    logic          mem_rd_r;
    logic          mem_wr_r;

    logic          pick_s;
    logic          any_s;
    logic          sel_we_s;
    logic [AW-1:0] sel_addr_s;
    logic [DW-1:0] sel_wdata_s;

    rr_pick2 u_pick (
        .req    ({req1, req0}),
        .last   (last_r),
        .winner (pick_s),
        .any    (any_s)
    );

    // Route the picked requester's transaction fields toward the latch registers.
    always_comb begin
        sel_we_s    = we0;
        sel_addr_s  = addr0;
        sel_wdata_s = wdata0;
        if (pick_s == REQ_DMA) begin
            sel_we_s    = we1;
            sel_addr_s  = addr1;
            sel_wdata_s = wdata1;
        end else begin
            sel_we_s    = we0;
            sel_addr_s  = addr0;
            sel_wdata_s = wdata0;
        end
    end

    // Sequencer and datapath registers; memory strobes are set on entry to
    // ACCESS so they are registered and high for exactly that one cycle.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_r  <= ST_IDLE;
            last_r   <= REQ_DMA;
            win_r    <= REQ_CPU;
            we_r     <= 1'b0;
            addr_r   <= '0;
            wdata_r  <= '0;
            rdata_r  <= '0;
            grant_r  <= 2'b00;
            ack0_r   <= 1'b0;
            ack1_r   <= 1'b0;
            mem_rd_r <= 1'b0;
            mem_wr_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ack0_r <= 1'b0;
                    ack1_r <= 1'b0;
                    if (any_s) begin
                        win_r    <= pick_s;
                        we_r     <= sel_we_s;
                        addr_r   <= sel_addr_s;
                        wdata_r  <= sel_wdata_s;
                        mem_rd_r <= ~sel_we_s;
                        mem_wr_r <= sel_we_s;
                        grant_r  <= (pick_s == REQ_DMA) ? 2'b10 : 2'b01;
                        state_r  <= ST_ACCESS;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    mem_rd_r <= 1'b0;
                    mem_wr_r <= 1'b0;
                    // Writes leave the previous read data in place.
                    if (!we_r) begin
                        rdata_r <= mem_rdata;
                    end else begin
                        rdata_r <= rdata_r;
                    end
                    ack0_r  <= (win_r == REQ_CPU);
                    ack1_r  <= (win_r == REQ_DMA);
                    state_r <= ST_RESP;
                end
                ST_RESP: begin
                    ack0_r  <= 1'b0;
                    ack1_r  <= 1'b0;
                    grant_r <= 2'b00;
                    last_r  <= win_r;
                    state_r <= ST_IDLE;
                end
                default: begin
                    ack0_r   <= 1'b0;
                    ack1_r   <= 1'b0;
                    grant_r  <= 2'b00;
                    mem_rd_r <= 1'b0;
                    mem_wr_r <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack0      = ack0_r;
    assign ack1      = ack1_r;
    assign rdata     = rdata_r;
    assign grant     = grant_r;
    assign mem_rd    = mem_rd_r;
    assign mem_wr    = mem_wr_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    // Combinational so the ControlUnit can hold the PC in the same cycle req0 rises.
    assign cpu_stall = req0 & ~ack0_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic        CLK;
    logic        Reset;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        ack0, ack1, cpu_stall, mem_rd, mem_wr;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  grant;

    logic [31:0] bmem [0:255];

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.AW(32), .DW(32)) dut (
        .CLK(CLK), .Reset(Reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
        .rdata(rdata), .grant(grant), .cpu_stall(cpu_stall),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // DataMemory stand-in: asynchronous read, write on rising edge.
    assign mem_rdata = bmem[mem_addr[9:2]];
    always @(posedge CLK) begin
        if (mem_wr) bmem[mem_addr[9:2]] <= mem_wdata;
    end

    typedef struct {
        logic        who;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_reqs();
        req0 = 1'b0; we0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0;
        req1 = 1'b0; we1 = 1'b0; addr1 = 32'h0; wdata1 = 32'h0;
    endtask

    // Reset for two cycles; returns at the negedge where Reset has just dropped.
    task automatic do_reset();
        Reset = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        Reset = 1'b0;
    endtask

    // One isolated transaction with fixed IDLE/ACCESS/RESP timing.
    task automatic run_txn(input vec_t v);
        if (v.who) begin
            req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata;
        end else begin
            req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata;
        end
        @(negedge CLK);
        chk("txn_access_rd", {31'd0, mem_rd}, {31'd0, ~v.we});
        chk("txn_access_wr", {31'd0, mem_wr}, {31'd0, v.we});
        chk("txn_access_addr", mem_addr, v.addr);
        chk("txn_access_grant", {30'd0, grant}, v.who ? 32'd2 : 32'd1);
        chk("txn_access_ack", {30'd0, ack1, ack0}, 32'd0);
        chk("txn_access_stall", {31'd0, cpu_stall}, {31'd0, ~v.who});
        @(negedge CLK);
        chk("txn_resp_ack", {30'd0, ack1, ack0}, v.who ? 32'd2 : 32'd1);
        chk("txn_resp_rdata", rdata, v.exp_rdata);
        chk("txn_resp_strobe", {30'd0, mem_rd, mem_wr}, 32'd0);
        chk("txn_resp_stall", {31'd0, cpu_stall}, 32'd0);
        clear_reqs();
        @(negedge CLK);
        chk("txn_idle_grant", {30'd0, grant}, 32'd0);
        chk("txn_idle_ack", {30'd0, ack1, ack0}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) bmem[i] = 32'h0;
        bmem[8'h02] = 32'h12345678;   // 0x08
        bmem[8'h08] = 32'hA0A0A0A0;   // 0x20
        bmem[8'h09] = 32'hB1B1B1B1;   // 0x24
        bmem[8'h0A] = 32'hC2C2C2C2;   // 0x28

        vecs[0] = '{who: 1'b0, we: 1'b0, addr: 32'h08, wdata: 32'h0,         exp_rdata: 32'h12345678};
        vecs[1] = '{who: 1'b1, we: 1'b1, addr: 32'h30, wdata: 32'hDEADBEEF, exp_rdata: 32'h12345678};
        vecs[2] = '{who: 1'b1, we: 1'b0, addr: 32'h30, wdata: 32'h0,         exp_rdata: 32'hDEADBEEF};
        vecs[3] = '{who: 1'b0, we: 1'b1, addr: 32'h34, wdata: 32'h55AA55AA, exp_rdata: 32'hDEADBEEF};
        vecs[4] = '{who: 1'b0, we: 1'b0, addr: 32'h34, wdata: 32'h0,         exp_rdata: 32'h55AA55AA};

        clear_reqs();
        Reset = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        // Reset values.
        chk("rst_ack", {30'd0, ack1, ack0}, 32'd0);
        chk("rst_strobe", {30'd0, mem_rd, mem_wr}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_grant", {30'd0, grant}, 32'd0);
        chk("rst_stall_lo", {31'd0, cpu_stall}, 32'd0);
        // Request during reset: reset wins, stall follows req0.
        req0 = 1'b1; addr0 = 32'h08;
        @(negedge CLK);
        chk("rst_req_grant", {30'd0, grant}, 32'd0);
        chk("rst_req_rd", {31'd0, mem_rd}, 32'd0);
        chk("rst_stall_hi", {31'd0, cpu_stall}, 32'd1);
        clear_reqs();
        Reset = 1'b0;
        @(negedge CLK);

        // Table-driven single transactions.
        for (int i = 0; i < 5; i++) run_txn(vecs[i]);
        chk("mem_dma_write", bmem[8'h0C], 32'hDEADBEEF);
        chk("mem_cpu_write", bmem[8'h0D], 32'h55AA55AA);

        // Continuous contention from reset release: CPU, DMA, CPU, DMA.
        do_reset();
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h10; wdata0 = 32'hAAAA0000;
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h14; wdata1 = 32'h0000BBBB;
        for (int cyc = 2; cyc <= 12; cyc++) begin
            @(negedge CLK);
            chk($sformatf("rr_ack0_c%0d", cyc), {31'd0, ack0}, (cyc == 3 || cyc == 9) ? 32'd1 : 32'd0);
            chk($sformatf("rr_ack1_c%0d", cyc), {31'd0, ack1}, (cyc == 6 || cyc == 12) ? 32'd1 : 32'd0);
            chk($sformatf("rr_grant_c%0d", cyc), {30'd0, grant},
                (cyc == 2 || cyc == 3 || cyc == 8 || cyc == 9) ? 32'd1 :
                (cyc == 5 || cyc == 6 || cyc == 11 || cyc == 12) ? 32'd2 : 32'd0);
        end
        clear_reqs();
        @(negedge CLK);
        chk("rr_mem_cpu", bmem[8'h04], 32'hAAAA0000);
        chk("rr_mem_dma", bmem[8'h05], 32'h0000BBBB);

        // DMA back-to-back reads with req1 held high.
        begin
            logic [31:0] exp_rd [3];
            int k;
            exp_rd[0] = 32'hA0A0A0A0; exp_rd[1] = 32'hB1B1B1B1; exp_rd[2] = 32'hC2C2C2C2;
            k = 0;
            req1 = 1'b1; we1 = 1'b0; addr1 = 32'h20;
            for (int cyc = 2; cyc <= 9; cyc++) begin
                @(negedge CLK);
                chk($sformatf("b2b_ack1_c%0d", cyc), {31'd0, ack1}, (cyc % 3 == 0) ? 32'd1 : 32'd0);
                chk($sformatf("b2b_ack0_c%0d", cyc), {31'd0, ack0}, 32'd0);
                if (cyc % 3 == 2) chk($sformatf("b2b_addr_c%0d", cyc), mem_addr, 32'h20 + 32'(4 * k));
                if (cyc % 3 == 0) begin
                    chk($sformatf("b2b_rdata_%0d", k), rdata, exp_rd[k]);
                    k++;
                    addr1 = 32'h20 + 32'(4 * k);
                end
            end
            clear_reqs();
            @(negedge CLK);
        end

        // Reset during ACCESS of a CPU write; transfer is regranted afterwards.
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h40; wdata0 = 32'h0BADF00D;
        @(negedge CLK);
        chk("abort_access_wr", {31'd0, mem_wr}, 32'd1);
        Reset = 1'b1;
        @(negedge CLK);
        chk("abort_ack0", {31'd0, ack0}, 32'd0);
        chk("abort_wr_low", {31'd0, mem_wr}, 32'd0);
        chk("abort_grant", {30'd0, grant}, 32'd0);
        Reset = 1'b0;
        @(negedge CLK);
        chk("regrant_wr", {31'd0, mem_wr}, 32'd1);
        chk("regrant_grant", {30'd0, grant}, 32'd1);
        chk("regrant_ack_early", {31'd0, ack0}, 32'd0);
        @(negedge CLK);
        chk("regrant_ack0", {31'd0, ack0}, 32'd1);
        clear_reqs();
        @(negedge CLK);
        chk("regrant_mem", bmem[8'h10], 32'h0BADF00D);

        // Requester inputs change during ACCESS: latched values must hold.
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h50; wdata0 = 32'h600DCAFE;
        @(negedge CLK);
        chk("latch_access_addr", mem_addr, 32'h50);
        chk("latch_access_wdata", mem_wdata, 32'h600DCAFE);
        addr0 = 32'h54; wdata0 = 32'hFFFFFFFF;
        @(negedge CLK);
        chk("latch_resp_ack0", {31'd0, ack0}, 32'd1);
        chk("latch_resp_addr", mem_addr, 32'h50);
        chk("latch_resp_wdata", mem_wdata, 32'h600DCAFE);
        clear_reqs();
        @(negedge CLK);
        chk("latch_single_ack", {31'd0, ack0}, 32'd0);
        chk("latch_mem_hit", bmem[8'h14], 32'h600DCAFE);
        chk("latch_mem_untouched", bmem[8'h15], 32'h0);

        // Idle for 20 cycles.
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge CLK);
            chk($sformatf("idle_c%0d", cyc), {26'd0, mem_rd, mem_wr, grant, ack0 | ack1, cpu_stall}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
